// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: halts the CPU on a write to the DMA register, then
// copies one 256-byte page to a fixed destination port as read/write pairs.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dor,
    input  logic        cpu_rw,
    input  logic        i_ready,
    input  logic [7:0]  i_data,
    output logic        cpu_ready,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        rw,
    output logic        busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                parity_q;
    logic [BYTE_W-1:0]   page_q, page_d;
    logic [BYTE_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]   buf_q, buf_d;
    logic                trigger;

    // Trigger decode looks at the raw CPU address, never the muxed bus.
    assign trigger = (cpu_rw == 1'b0) && (cpu_addr == DMA_REG_ADDR);

    // State, transfer pointers and read buffer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    // Free-running cycle parity; READ is aligned so it always lands on parity 0.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end

    // Next-state logic and datapath updates.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_dor;
                    idx_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // The CPU only stalls on a read, so wait for one.
                if (cpu_rw) begin
                    state_d = parity_q ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                buf_d   = i_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory bus mux: CPU owns the bus except during READ and WRITE.
    always_comb begin
        addr = cpu_addr;
        dout = cpu_dor;
        rw   = cpu_rw;
        unique case (state_q)
            S_READ: begin
                addr = ADDR_W'({page_q, idx_q});
                rw   = 1'b1;
            end
            S_WRITE: begin
                addr = DEST_ADDR;
                dout = buf_q;
                rw   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // CPU handshake and status.
    assign busy      = (state_q != S_IDLE);
    assign cpu_ready = i_ready & (state_q == S_IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected DMA bus cycles are queued at
// trigger time and popped as the monitor observes DMA-owned bus cycles.
module tb_oam_dma_ctrl;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] DEST    = 16'h2004;
    localparam logic [15:0] CPU_PARK = 16'hC0DE;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dor;
    logic        cpu_rw;
    logic        i_ready;
    logic [7:0]  i_data;
    logic        cpu_ready;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rw;
    logic        busy;

    typedef struct {
        logic [15:0] a;
        bit          wr;
        logic [7:0]  d;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  wr_cnt  = 0;
    bit  tb_par;

    oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014), .DEST_ADDR(16'h2004)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .cpu_addr  (cpu_addr),
        .cpu_dor   (cpu_dor),
        .cpu_rw    (cpu_rw),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .cpu_ready (cpu_ready),
        .addr      (addr),
        .dout      (dout),
        .rw        (rw),
        .busy      (busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory contents seen on the read data bus.
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] + 8'h5A);
    endfunction

    assign i_data = mem_rd(addr);

    // Reference cycle parity: 0 out of reset, toggles every clock.
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: any busy cycle whose bus address differs from the CPU's is a DMA cycle.
    always @(negedge i_clk) begin
        if (i_rst && busy && (addr !== cpu_addr)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dma", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check(e.wr ? "wr_addr" : "rd_addr", 32'(addr), 32'(e.a));
                check(e.wr ? "wr_rw" : "rd_rw", 32'(rw), e.wr ? 32'd0 : 32'd1);
                if (e.wr) begin
                    check("wr_data", 32'(dout), 32'(e.d));
                    wr_cnt++;
                end else begin
                    check("rd_parity", 32'(tb_par), 32'd0);
                    check("rd_dout", 32'(dout), 32'(cpu_dor));
                end
            end
        end
    end

    task automatic run_dma(input logic [7:0] page, input bit halt_par, input int stretch,
                           input bit glitch, input bit busy_trig, input bit abort);
        int  low;
        int  exp_low;
        int  base;
        bit  done;
        bit  par_exit;
        ev_t e;
        @(posedge i_clk); #1;
        // Choose the trigger cycle so HALT lands on the requested parity.
        for (int k = 0; k < 2 && tb_par == halt_par; k++) begin
            @(posedge i_clk); #1;
        end
        for (int i = 0; i < 256; i++) begin
            e.a = {page, 8'(i)}; e.wr = 1'b0; e.d = 8'h00;
            exp_q.push_back(e);
            e.a = DEST; e.wr = 1'b1; e.d = mem_rd({page, 8'(i)});
            exp_q.push_back(e);
        end
        base = wr_cnt;
        check("idle_ready", 32'(cpu_ready), 32'd1);
        cpu_addr = DMA_REG; cpu_dor = page; cpu_rw = 1'b0;
        @(posedge i_clk); #1;
        check("halt_busy", 32'(busy), 32'd1);
        check("halt_ready", 32'(cpu_ready), 32'd0);
        check("halt_addr", 32'(addr), 32'(DMA_REG));
        cpu_addr = CPU_PARK; cpu_dor = 8'h3C; cpu_rw = (stretch == 0);
        par_exit = halt_par ^ stretch[0];
        exp_low = stretch + (par_exit ? 513 : 514);
        low = 1;
        done = 1'b0;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(posedge i_clk); #1;
            if (cyc <= stretch) begin
                check("stretch_busy", 32'(busy), 32'd1);
                check("stretch_addr", 32'(addr), 32'(cpu_addr));
                check("stretch_rw", 32'(rw), 32'(cpu_rw));
                cpu_rw = (cyc >= stretch);
            end
            if (abort && (wr_cnt - base) == 8'h40 && busy && rw == 1'b0 && addr == DEST) begin
                i_rst = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_ready", 32'(cpu_ready), 32'd1);
                check("abort_addr", 32'(addr), 32'(cpu_addr));
                exp_q.delete();
                repeat (2) @(posedge i_clk);
                #1 i_rst = 1'b1;
                check("post_abort_busy", 32'(busy), 32'd0);
                repeat (5) @(posedge i_clk);
                #1;
                check("post_abort_idle", 32'(busy), 32'd0);
                check("abort_wr_count", 32'(wr_cnt - base), 32'h40);
                return;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
            low++;
            if (glitch) begin
                i_ready = !(cyc >= 50 && cyc < 60);
                if (cyc == 55) check("glitch_ready", 32'(cpu_ready), 32'd0);
            end
            if (busy_trig && cyc == 101) begin
                cpu_addr = DMA_REG; cpu_rw = 1'b0; cpu_dor = 8'h77;
            end
            if (busy_trig && cyc == 102) begin
                cpu_addr = CPU_PARK; cpu_rw = 1'b1; cpu_dor = 8'h3C;
            end
        end
        check("dma_done", 32'(done), 32'd1);
        check("low_cycles", 32'(low), 32'(exp_low));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("wr_count", 32'(wr_cnt - base), 32'd256);
        i_ready = 1'b1;
        #1;
        check("end_ready", 32'(cpu_ready), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        i_rst = 1'b0; cpu_addr = 16'h1234; cpu_dor = 8'hA7; cpu_rw = 1'b1; i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_addr", 32'(addr), 32'h1234);
        check("rst_rw", 32'(rw), 32'd1);
        check("rst_dout", 32'(dout), 32'hA7);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cpu_ready), 32'd1);
        i_ready = 1'b0;
        #1 check("rst_ready_gated", 32'(cpu_ready), 32'd0);
        i_ready = 1'b1;
        @(posedge i_clk); #1 i_rst = 1'b1;
        cpu_addr = CPU_PARK;
        check("post_rst_busy", 32'(busy), 32'd0);

        run_dma(8'h02, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        run_dma(8'h02, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_dma(8'h11, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        run_dma(8'hFF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_dma(8'h35, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        run_dma(8'h02, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        run_dma(8'h03, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        repeat (4) @(posedge i_clk);
        #1 check("final_idle", 32'(busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
